insn_loader: RTL and testbench

Host-side writer for the accelerator instruction memory. It accepts a program as a valid/ready stream of 32-bit instruction words and stores it in an 8192-entry instruction store. It then releases the instruction decoder from reset and serves its fetches (`iaddr` → `idata`) with combinational read. It sits between the host DMA/bridge and the decoder, and replaces the testbench-preloaded instruction ROM.

---
 rtl/insn_loader.sv | 125 ++++++++++++
 tb/tb_insn_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/insn_loader.sv
// Host-side loader for the accelerator instruction store: accepts a program as a
// valid/ready word stream, then holds the decoder out of reset and serves its fetches.
module insn_loader #(
  parameter int unsigned DEPTH  = 8192,
  parameter logic [4:0]  OP_EOC = 5'h1E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic [13:0] ld_len,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        ld_abort,
  output logic        ld_err,
  output logic [13:0] ld_count,
  output logic [31:0] checksum,
  output logic        busy,
  output logic        dec_rst_n,
  input  logic [12:0] iaddr,
  output logic [31:0] idata
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [13:0] len_q, len_d;
  logic [13:0] count_q, count_d;
  logic [31:0] sum_q, sum_d;
  logic        eoc_q, eoc_d;
  logic        err_q, err_d;
  logic        eoc_now;
  logic        wr_en;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    sum_d   = sum_q;
    eoc_d   = eoc_q;
    err_d   = err_q;
    eoc_now = eoc_q | (ld_data[31:27] == OP_EOC);
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          if (ld_len != '0 && ld_len <= 14'(DEPTH)) begin
            len_d   = ld_len;
            count_d = '0;
            sum_d   = '0;
            eoc_d   = 1'b0;
            err_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // Abort takes priority over a handshake in the same cycle.
        if (ld_abort) begin
          state_d = S_IDLE;
        end else if (ld_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + 14'd1;
          sum_d   = sum_q + ld_data;
          eoc_d   = eoc_now;
          if (count_q == len_q - 14'd1) begin
            if (eoc_now) begin
              state_d = S_RUN;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_RUN: begin
        if (ld_abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      eoc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      eoc_q   <= eoc_d;
      err_q   <= err_d;
    end
  end

  // Store contents are deliberately not reset; reads are bounded by len_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[12:0]] <= ld_data;
  end

  always_comb begin
    idata = '0;
    if (state_q == S_RUN) begin
      if ({1'b0, iaddr} < len_q) idata = mem[iaddr];
      else                       idata = {OP_EOC, 27'b0};
    end
  end

  assign ld_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD);
  assign dec_rst_n = (state_q == S_RUN);
  assign ld_err    = err_q;
  assign ld_count  = count_q;
  assign checksum  = sum_q;

endmodule

// File: tb/tb_insn_loader.sv
// Scoreboard bench for insn_loader: directed programs, a handshake monitor that pops
// expected (address, word) pairs, and direct checks of status and fetch outputs.
module tb_insn_loader;

  localparam logic [31:0] EOC = 32'hF000_0000;

  logic        clk, rst;
  logic        ld_start, ld_valid, ld_abort;
  logic [13:0] ld_len;
  logic [31:0] ld_data;
  logic        ld_ready, ld_err, busy, dec_rst_n;
  logic [13:0] ld_count;
  logic [31:0] checksum, idata;
  logic [12:0] iaddr;

  int checks   = 0;
  int failures = 0;
  logic [45:0] exp_q [$];

  insn_loader #(.DEPTH(8192), .OP_EOC(5'h1E)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_abort(ld_abort), .ld_err(ld_err), .ld_count(ld_count),
    .checksum(checksum), .busy(busy), .dec_rst_n(dec_rst_n),
    .iaddr(iaddr), .idata(idata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the next expected address/data pair.
  always @(negedge clk) begin
    if (!rst && ld_valid && ld_ready && !ld_abort) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accept", {18'b0, ld_count}, 32'hFFFF_FFFF);
      end else begin
        logic [45:0] e;
        e = exp_q.pop_front();
        check("accept_addr", {18'b0, ld_count}, {18'b0, e[45:32]});
        check("accept_data", ld_data, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [13:0] len);
    ld_start = 1'b1;
    ld_len   = len;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic word(input logic [13:0] addr, input logic [31:0] data);
    ld_valid = 1'b1;
    ld_data  = data;
    exp_q.push_back({addr, data});
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic bubble();
    ld_valid = 1'b0;
    ld_data  = 32'hDEAD_BEEF;
    tick();
  endtask

  task automatic fetch(input string name, input logic [12:0] a, input logic [31:0] exp);
    iaddr = a;
    #1;
    check(name, idata, exp);
  endtask

  task automatic abort_cycle();
    ld_abort = 1'b1;
    tick();
    ld_abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0;
    ld_data = '0; ld_abort = 1'b0; iaddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ld_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_dec_rst_n", {31'b0, dec_rst_n}, 32'd0);
    check("rst_err", {31'b0, ld_err}, 32'd0);
    check("rst_count", {18'b0, ld_count}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_idata", idata, 32'd0);
    rst = 1'b0;
    tick();

    // Normal 4-word load, valid held high.
    start(14'd4);
    check("norm_ready_t1", {31'b0, ld_ready}, 32'd1);
    word(14'd0, 32'h0800_0001);
    word(14'd1, 32'h1000_0002);
    word(14'd2, 32'h1800_0003);
    word(14'd3, EOC);
    check("norm_ready_off", {31'b0, ld_ready}, 32'd0);
    check("norm_dec_rst_n", {31'b0, dec_rst_n}, 32'd1);
    check("norm_count", {18'b0, ld_count}, 32'd4);
    check("norm_checksum", checksum, 32'h2000_0006);
    fetch("norm_fetch2", 13'd2, 32'h1800_0003);
    fetch("norm_fetch7", 13'd7, EOC);
    fetch("norm_fetch0", 13'd0, 32'h0800_0001);
    // A start pulse in RUN is ignored, even with an illegal length.
    start(14'd0);
    check("run_start_err", {31'b0, ld_err}, 32'd0);
    check("run_start_dec", {31'b0, dec_rst_n}, 32'd1);
    abort_cycle();
    check("run_abort_dec", {31'b0, dec_rst_n}, 32'd0);
    check("run_abort_idata", idata, 32'd0);
    check("run_abort_count", {18'b0, ld_count}, 32'd4);

    // Bubbles: valid pattern 1,0,0,1,1 on a 3-word program.
    start(14'd3);
    word(14'd0, 32'h0000_0011);
    bubble();
    bubble();
    word(14'd1, 32'h2000_0022);
    word(14'd2, 32'hF000_0033);
    check("bub_count", {18'b0, ld_count}, 32'd3);
    check("bub_dec_rst_n", {31'b0, dec_rst_n}, 32'd1);
    check("bub_checksum", checksum, 32'h1000_0066);
    fetch("bub_fetch0", 13'd0, 32'h0000_0011);
    fetch("bub_fetch1", 13'd1, 32'h2000_0022);
    fetch("bub_fetch2", 13'd2, 32'hF000_0033);
    fetch("bub_fetch3", 13'd3, EOC);
    abort_cycle();

    // Length errors, then recovery with a 1-word program.
    start(14'd0);
    check("len0_err", {31'b0, ld_err}, 32'd1);
    check("len0_ready", {31'b0, ld_ready}, 32'd0);
    check("len0_busy", {31'b0, busy}, 32'd0);
    start(14'd8193);
    check("len8193_err", {31'b0, ld_err}, 32'd1);
    check("len8193_ready", {31'b0, ld_ready}, 32'd0);
    start(14'd1);
    check("len1_err_clr", {31'b0, ld_err}, 32'd0);
    check("len1_ready", {31'b0, ld_ready}, 32'd1);
    word(14'd0, 32'hF000_0ABC);
    check("len1_dec_rst_n", {31'b0, dec_rst_n}, 32'd1);
    fetch("len1_fetch0", 13'd0, 32'hF000_0ABC);
    fetch("len1_fetch1", 13'd1, EOC);
    abort_cycle();

    // Missing EOC.
    start(14'd3);
    word(14'd0, 32'h0800_0001);
    word(14'd1, 32'h1000_0002);
    word(14'd2, 32'h1800_0003);
    check("noeoc_err", {31'b0, ld_err}, 32'd1);
    check("noeoc_dec_rst_n", {31'b0, dec_rst_n}, 32'd0);
    check("noeoc_ready", {31'b0, ld_ready}, 32'd0);
    check("noeoc_count", {18'b0, ld_count}, 32'd3);
    tick();
    check("noeoc_dec_hold", {31'b0, dec_rst_n}, 32'd0);

    // Abort coinciding with the handshake of word 2 of 5.
    start(14'd5);
    word(14'd0, 32'h0000_0100);
    word(14'd1, 32'h0000_0200);
    ld_abort = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'h0000_0400;
    tick();
    ld_abort = 1'b0;
    ld_valid = 1'b0;
    check("abort_count", {18'b0, ld_count}, 32'd2);
    check("abort_checksum", checksum, 32'h0000_0300);
    check("abort_ready", {31'b0, ld_ready}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);

    // Full depth with checksum wrap.
    start(14'd8192);
    for (int i = 0; i < 8192; i++) word(14'(i), (i == 8191) ? EOC : 32'hFFFF_FFFF);
    check("full_count", {18'b0, ld_count}, 32'd8192);
    check("full_checksum", checksum, 32'hEFFF_E001);
    check("full_dec_rst_n", {31'b0, dec_rst_n}, 32'd1);
    fetch("full_fetch100", 13'd100, 32'hFFFF_FFFF);
    fetch("full_fetch8191", 13'd8191, EOC);
    abort_cycle();

    // Asynchronous reset in the middle of a load.
    start(14'd10);
    word(14'd0, 32'h0000_0001);
    word(14'd1, 32'h0000_0002);
    word(14'd2, 32'h0000_0003);
    ld_valid = 1'b1;
    ld_data  = 32'h0000_0004;
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", {31'b0, ld_ready}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_count", {18'b0, ld_count}, 32'd0);
    check("arst_checksum", checksum, 32'd0);
    check("arst_err", {31'b0, ld_err}, 32'd0);
    check("arst_idata", idata, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("arst_no_resume", {31'b0, ld_ready}, 32'd0);
    ld_valid = 1'b0;
    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
